// File: rtl/eight_bit_seq_multiplier_pkg.sv
// Shared constants for the sequential 8x8 shift-add multiplier:
// FSM state encoding, operand/product widths and iteration count.
package eight_bit_seq_multiplier_pkg;

  localparam int OPERAND_W  = 8;
  localparam int PRODUCT_W  = 16;
  localparam int ITER_COUNT = 8;
  localparam logic [3:0] LAST_COUNT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/eight_bit_adder.sv
// Existing 8-bit adder/subtractor used by the multiplier datapath.
// opcode 0 = A + B, opcode 1 = A - B (two's complement).
// Carry is the unsigned carry out, Overflow the signed overflow flag.
module eight_bit_adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       opcode,
  output logic [7:0] Sum,
  output logic       Carry,
  output logic       Overflow
);

  logic [7:0] w_b_eff;
  logic [8:0] w_sum_ext;

  // Invert B and inject a carry-in of 1 for subtraction.
  assign w_b_eff   = opcode ? ~B : B;
  assign w_sum_ext = {1'b0, A} + {1'b0, w_b_eff} + {8'd0, opcode};
  assign Sum       = w_sum_ext[7:0];
  assign Carry     = w_sum_ext[8];
  assign Overflow  = (A[7] == w_b_eff[7]) && (w_sum_ext[7] != A[7]);

endmodule

// File: rtl/eight_bit_seq_multiplier.sv
// Sequential unsigned 8x8 shift-add multiplier built on eight_bit_adder.
// Handshake: start is sampled only in IDLE; busy is high in RUN and DONE;
// done is a one-cycle pulse in DONE, when product holds the new result.
// Optional macro EIGHT_BIT_MULT_ZERO_BYPASS_EN: a zero operand skips the
// iterations and goes IDLE->DONE on the accepting edge with product = 0.
module eight_bit_seq_multiplier
  import eight_bit_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = OPERAND_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           dbg_state
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [3:0]         r_count;
  logic [2*WIDTH-1:0] r_product;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic               w_adder_ovf_unused;
  logic [WIDTH-1:0]   w_next_hi;
  logic [WIDTH-1:0]   w_next_lo;

  // Adder is permanently wired as acc_hi + mcand; overflow is meaningless
  // for unsigned arithmetic.
  eight_bit_adder ADDER (
    .A        (r_acc_hi),
    .B        (r_mcand),
    .opcode   (1'b0),
    .Sum      (w_sum),
    .Carry    (w_carry),
    .Overflow (w_adder_ovf_unused)
  );

  // One shift-add iteration: add mcand when the current multiplier bit is
  // set, then shift the 17-bit {carry, acc_hi, acc_lo} right by one.
  assign w_next_hi = r_acc_lo[0] ? {w_carry, w_sum[WIDTH-1:1]}
                                 : {1'b0, r_acc_hi[WIDTH-1:1]};
  assign w_next_lo = r_acc_lo[0] ? {w_sum[0], r_acc_lo[WIDTH-1:1]}
                                 : {r_acc_hi[0], r_acc_lo[WIDTH-1:1]};

  // FSM, accumulator shift registers, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
`ifdef EIGHT_BIT_MULT_ZERO_BYPASS_EN
            if ((multiplicand == '0) || (multiplier == '0)) begin
              r_state   <= ST_DONE;
              r_product <= '0;
              r_busy    <= 1'b1;
              r_done    <= 1'b1;
            end else begin
              r_state  <= ST_RUN;
              r_mcand  <= multiplicand;
              r_acc_hi <= '0;
              r_acc_lo <= multiplier;
              r_count  <= '0;
              r_busy   <= 1'b1;
            end
`else
            r_state  <= ST_RUN;
            r_mcand  <= multiplicand;
            r_acc_hi <= '0;
            r_acc_lo <= multiplier;
            r_count  <= '0;
            r_busy   <= 1'b1;
`endif
          end
        end
        ST_RUN: begin
          r_acc_hi <= w_next_hi;
          r_acc_lo <= w_next_lo;
          r_count  <= r_count + 4'd1;
          if (r_count == LAST_COUNT) begin
            r_state   <= ST_DONE;
            r_product <= {w_next_hi, w_next_lo};
            r_done    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign product   = r_product;
  assign dbg_state = r_state;

endmodule
